fifo_serial_tx: RTL and testbench

- Drain-side companion to the system-bus FIFO.
- Pops 32-bit words from the FIFO's dequeue port and shifts each word out MSB-first as a serial bit stream.
- Each bit uses a valid/ready handshake toward the downstream bus link.
- Sits between the FIFO read port and the serial system-bus physical link.

---
 rtl/fifo_serial_pkg.sv | 33 +++
 rtl/fifo_serial_shifter.sv | 62 ++++++
 rtl/fifo_serial_tx.sv | 147 ++++++++++++++
 tb/tb_fifo_serial_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_serial_pkg
// Description : Shared types and constants for the FIFO drain-side serial
//               transmitter: FSM state encoding, default widths and the
//               frame-length helper.
//               Optional feature macro: FIFO_SERIAL_TX_PARITY_EN
//               (appends an even-parity bit after the data LSB).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_serial_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        FETCH = 2'd2,
        SEND  = 2'd3
    } fsm_state_t;

    // Number of serial bits per frame for a given data width.
    function automatic int frame_bits(input int width);
`ifdef FIFO_SERIAL_TX_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage : fifo_serial_pkg
`default_nettype wire

// File: rtl/fifo_serial_shifter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_serial_shifter
// Description : Frame shift register for fifo_serial_tx. Loads a data word
//               (plus even parity when FIFO_SERIAL_TX_PARITY_EN is defined),
//               shifts it out MSB-first and flags the final bit of the frame.
// Ports       : clk, rstn        - clock, asynchronous active-low reset
//               i_load           - capture i_data, restart bit counter
//               i_shift_en       - one bit accepted downstream; advance
//               i_data[WIDTH]    - word to serialise
//               o_msb            - current serial bit
//               o_last           - current bit is the last of the frame
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_serial_shifter
    import fifo_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic             i_shift_en,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb,
    output logic             o_last
);

    localparam int c_FRAME_BITS = frame_bits(WIDTH);
    localparam int c_CNT_BW     = $clog2(c_FRAME_BITS + 1);
    localparam logic [c_CNT_BW-1:0] c_LAST_IDX = c_CNT_BW'(c_FRAME_BITS - 1);
    localparam logic [c_CNT_BW-1:0] c_CNT_ONE  = c_CNT_BW'(1);

    logic [c_FRAME_BITS-1:0] r_shreg;
    logic [c_CNT_BW-1:0]     r_bit_cnt;
    logic [c_FRAME_BITS-1:0] w_load_val;

`ifdef FIFO_SERIAL_TX_PARITY_EN
    // Even parity: the extra bit makes the total count of ones even.
    assign w_load_val = {i_data, ^i_data};
`else
    assign w_load_val = i_data;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_shreg   <= w_load_val;
            r_bit_cnt <= '0;
        end else if (i_shift_en) begin
            r_shreg   <= {r_shreg[c_FRAME_BITS-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
        end
    end

    assign o_msb  = r_shreg[c_FRAME_BITS-1];
    assign o_last = (r_bit_cnt == c_LAST_IDX);

endmodule : fifo_serial_shifter
`default_nettype wire

// File: rtl/fifo_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_serial_tx
// Description : Drain-side companion to the system-bus FIFO. Pops one word at
//               a time from the FIFO dequeue port and streams it MSB-first
//               over a per-bit valid/ready link.
//               Optional feature macro: FIFO_SERIAL_TX_PARITY_EN
//               (frame gains a trailing even-parity bit).
// Ports       : clk, rstn                    - clock, async active-low reset
//               fifo_data/empty/valid, fifo_deq - FIFO read side
//               tx_bit/valid/last, tx_ready  - serial link handshake
//               busy                         - FSM not in IDLE
//               fetch_err                    - pulse when FIFO never answers
//               word_count                   - completed frames (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_serial_tx
    import fifo_serial_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int FETCH_TIMEOUT = 8,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    input  logic             fifo_valid,
    output logic             fifo_deq,
    output logic             tx_bit,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy,
    output logic             fetch_err,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [7:0]       c_TMO_LAST = 8'(FETCH_TIMEOUT - 1);
    localparam logic [7:0]       c_TMO_ONE  = 8'd1;
    localparam logic [CNT_W-1:0] c_WC_ONE   = CNT_W'(1);

    fsm_state_t       r_state;
    fsm_state_t       w_next;
    logic [7:0]       r_tmo;
    logic [CNT_W-1:0] r_word_count;
    logic             w_load;
    logic             w_shift;
    logic             w_msb;
    logic             w_last;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        fifo_deq  = 1'b0;
        tx_valid  = 1'b0;
        busy      = 1'b1;
        fetch_err = 1'b0;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (!fifo_empty) begin
                    w_next = POP;
                end
            end
            POP: begin
                fifo_deq = 1'b1;
                w_next   = FETCH;
            end
            FETCH: begin
                // Valid data takes priority over a timeout in the same cycle.
                if (fifo_valid) begin
                    w_load = 1'b1;
                    w_next = SEND;
                end else if (r_tmo == c_TMO_LAST) begin
                    fetch_err = 1'b1;
                    w_next    = IDLE;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                w_shift  = tx_ready;
                if (tx_ready && w_last) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch timeout counter and sent-word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tmo <= '0;
        end else if (r_state == POP) begin
            r_tmo <= '0;
        end else if ((r_state == FETCH) && !fifo_valid) begin
            r_tmo <= r_tmo + c_TMO_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_word_count <= '0;
        end else if (w_shift && w_last) begin
            r_word_count <= r_word_count + c_WC_ONE;
        end
    end

    fifo_serial_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_load),
        .i_shift_en (w_shift),
        .i_data     (fifo_data),
        .o_msb      (w_msb),
        .o_last     (w_last)
    );

    // Serial outputs are forced low whenever no bit is being offered.
    assign tx_bit     = w_msb & tx_valid;
    assign tx_last    = w_last & tx_valid;
    assign word_count = r_word_count;

endmodule : fifo_serial_tx
`default_nettype wire

// File: tb/tb_fifo_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_serial_tx
// Description : Self-checking bench for fifo_serial_tx. A behavioural FIFO
//               answers dequeues; expected serial bits are queued when the
//               FIFO presents a word and popped as the link accepts bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_serial_tx;

`ifdef FIFO_SERIAL_TX_PARITY_EN
    localparam int FB = 33;
`else
    localparam int FB = 32;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_valid;
    logic        fifo_deq;
    logic        tx_bit;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic        fetch_err;
    logic [15:0] word_count;

    fifo_serial_tx #(
        .WIDTH         (32),
        .FETCH_TIMEOUT (8),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_valid (fifo_valid),
        .fifo_deq   (fifo_deq),
        .tx_bit     (tx_bit),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .busy       (busy),
        .fetch_err  (fetch_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] fifo_q[$];
    logic [1:0]  exp_q[$];     // {bit, last}
    int          cyc      = 0;
    int          n_deq    = 0;
    int          deq_cyc  = 0;
    int          deq_prev = 0;
    int          n_err    = 0;
    int          err_cyc  = 0;
    int          n_bits   = 0;
    logic        withhold = 1'b0;
    logic        pend     = 1'b0;
    logic [31:0] pend_word;
    logic        hold_prev = 1'b0;
    logic        bit_prev  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_expected(input logic [31:0] w);
        logic [FB-1:0] frame;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        frame = {w, ^w};
`else
        frame = w;
`endif
        for (int i = FB - 1; i >= 0; i--) begin
            exp_q.push_back({frame[i], (i == 0) ? 1'b1 : 1'b0});
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural FIFO: valid with data one cycle after a dequeue.
    initial begin
        fifo_valid = 1'b0;
        fifo_data  = '0;
        fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            fifo_valid = 1'b0;
            if (!rstn) begin
                pend = 1'b0;
            end else begin
                if (pend && !withhold) begin
                    fifo_valid = 1'b1;
                    fifo_data  = pend_word;
                    push_expected(pend_word);
                end
                pend = 1'b0;
                if (fifo_deq) begin
                    check("deq_not_empty", 32'(fifo_q.size() > 0), 32'd1);
                    n_deq++;
                    deq_prev = deq_cyc;
                    deq_cyc  = cyc;
                    if (fifo_q.size() > 0) begin
                        pend_word = fifo_q.pop_front();
                        pend      = 1'b1;
                    end
                end
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Link monitor and scoreboard consumer.
    initial forever begin
        @(negedge clk);
        #2;
        if (!rstn) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_bit", 32'(tx_bit), 32'(bit_prev));
            end
            if (fetch_err) begin
                n_err++;
                err_cyc = cyc;
            end
            if (tx_valid && tx_ready) begin
                n_bits++;
                check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    check("tx_bit", 32'(tx_bit), 32'(e[1]));
                    check("tx_last", 32'(tx_last), 32'(e[0]));
                end
            end
            hold_prev = tx_valid && !tx_ready;
            bit_prev  = tx_bit;
        end
    end

    initial begin
        int base;
        int n;
        rstn     = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {10'd0, fifo_deq, tx_bit, tx_valid, tx_last, busy, fetch_err, word_count}, 32'd0);
        rstn = 1'b1;

        // Empty FIFO: nothing happens.
        repeat (20) begin
            @(negedge clk);
            #3;
            check("idle_quiet", {29'd0, busy, tx_valid, fifo_deq}, 32'd0);
        end
        check("idle_no_deq", n_deq, 0);
        check("idle_wc", 32'(word_count), 32'd0);

        // Two back-to-back words at full rate.
        @(negedge clk);
        tx_ready = 1'b1;
        fifo_q.push_back(32'hA5A5_0001);
        fifo_q.push_back(32'h1234_5678);
        n = 0;
        while (word_count != 16'd2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("full_rate_wc", 32'(word_count), 32'd2);
        check("full_rate_deq_gap", deq_cyc - deq_prev, FB + 3);

        // Seventeen words with ready toggling every cycle.
        for (int i = 0; i <= 16; i++) fifo_q.push_back(32'(i));
        n = 0;
        while (word_count != 16'd19 && n < 3000) begin
            @(negedge clk);
            tx_ready = ~tx_ready;
            n++;
        end
        tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        check("toggle_wc", 32'(word_count), 32'd19);
        check("toggle_deq_count", n_deq, 19);
        check("toggle_idle", 32'(busy), 32'd0);

        // FIFO never answers: fetch timeout.
        withhold = 1'b1;
        fifo_q.push_back(32'hDEAD_BEEF);
        n = 0;
        while (n_err == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        #3;
        check("tmo_err_count", n_err, 1);
        check("tmo_err_delay", err_cyc - deq_cyc, 8);
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_wc", 32'(word_count), 32'd19);
        withhold = 1'b0;

        // Asynchronous reset in the middle of a frame.
        base = n_bits;
        fifo_q.push_back(32'h0F0F_3C3C);
        n = 0;
        while (n_bits < base + 10 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("mid_frame_reached", n_bits - base, 10);
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", {10'd0, fifo_deq, tx_bit, tx_valid, tx_last, busy, fetch_err, word_count}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        base = n_deq;
        fifo_q.push_back(32'h1357_9BDF);
        n = 0;
        while (word_count != 16'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #3;
        check("post_reset_wc", 32'(word_count), 32'd1);
        check("post_reset_deq", n_deq - base, 1);

`ifdef FIFO_SERIAL_TX_PARITY_EN
        fifo_q.push_back(32'h0000_0007);
        base = n_bits;
        n = 0;
        while (word_count != 16'd2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #3;
        check("parity_wc", 32'(word_count), 32'd2);
        check("parity_bits", n_bits - base, 33);
`endif

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_serial_tx
`default_nettype wire
